inst_fetch_queue: RTL

//  Parametrised instruction queue between InstCache/fetch and Decoder; successor to the single-width FIFO.

---
 rtl/inst_fetch_queue_pkg.sv | 17 +
 rtl/inst_fetch_queue_if.sv | 32 +++
 rtl/inst_fetch_queue_iq_entry_ram.sv | 21 ++
 rtl/inst_fetch_queue.sv | 95 +++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared widths, default sizing and entry layout for the instruction fetch queue.
package inst_fetch_queue_pkg;
   localparam int INST_ADDR_WIDTH = 32;
   localparam int INST_WIDTH      = 32;
   localparam int IQ_DEPTH        = 16;
   localparam int IQ_SLACK        = 2;

   // Entry layout: {pc, inst}, inst in the low bits
   localparam int IQ_INST_OFS = 0;
   localparam int IQ_PC_OFS   = INST_WIDTH;
   localparam int IQ_ENTRY_W  = INST_ADDR_WIDTH + INST_WIDTH;

   typedef struct packed {
      logic [INST_ADDR_WIDTH-1:0] pc;
      logic [INST_WIDTH-1:0]      inst;
   } iq_entry_t;
endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch/decode side bundle of the instruction queue.
interface inst_fetch_queue_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 16
);
   logic                     cache_inst_enable;
   logic [ADDR_W-1:0]        cache_pc;
   logic [INST_W-1:0]        cache_inst;
   logic                     pc_stall;
   logic                     clear;
   logic                     dec_enable;
   logic [ADDR_W-1:0]        dec_pc;
   logic [INST_W-1:0]        dec_inst;
   logic                     dec_stall;
   logic [$clog2(DEPTH):0]   occupancy;
   logic                     overflow_err;

   modport master (
      output cache_inst_enable, cache_pc, cache_inst,
      output clear, dec_enable,
      input  pc_stall, dec_pc, dec_inst, dec_stall,
      input  occupancy, overflow_err
   );

   modport slave (
      input  cache_inst_enable, cache_pc, cache_inst,
      input  clear, dec_enable,
      output pc_stall, dec_pc, dec_inst, dec_stall,
      output occupancy, overflow_err
   );
endinterface

// File: rtl/inst_fetch_queue_iq_entry_ram.sv
// Entry storage: one synchronous write port, one asynchronous read port.
module iq_entry_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 64,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);
   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction queue between fetch and decode storing {pc, inst} per entry.
// Define IQ_BYPASS_EN to forward a write straight to decode when empty.
import inst_fetch_queue_pkg::*;

module inst_fetch_queue #(
   parameter int DEPTH             = IQ_DEPTH,
   parameter int ADDR_W            = INST_ADDR_WIDTH,
   parameter int INST_W            = INST_WIDTH,
   parameter int ALMOST_FULL_SLACK = IQ_SLACK,
   localparam int AW               = $clog2(DEPTH),
   localparam int CW               = $clog2(DEPTH) + 1,
   localparam int EW               = ADDR_W + INST_W
) (
   input  logic             clk,
   input  logic             rst,
   inst_fetch_queue_if.slave bus
);
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic          r_ovf;

   logic          w_empty;
   logic          w_full;
   logic          w_rd;
   logic          w_wr;
   logic          w_store;
   logic          w_byp;
   logic [EW-1:0] w_rdata;
   logic [EW-1:0] w_wdata;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_rd    = bus.dec_enable && !w_empty;
   assign w_wr    = bus.cache_inst_enable && (!w_full || w_rd);

`ifdef IQ_BYPASS_EN
   assign w_byp = w_empty && bus.cache_inst_enable
               && bus.dec_enable && !bus.clear;
`else
   assign w_byp = 1'b0;
`endif

   // A bypassed entry is consumed directly and never occupies a slot
   assign w_store = w_wr && !w_byp && !bus.clear;
   assign w_wdata = {bus.cache_pc, bus.cache_inst};

   iq_entry_ram #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_store),
      .i_waddr (r_tail),
      .i_wdata (w_wdata),
      .i_raddr (r_head),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else if (bus.clear) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_store) r_tail <= r_tail + AW'(1);
         if (w_rd)    r_head <= r_head + AW'(1);
         r_count <= r_count + CW'(w_store) - CW'(w_rd);
         if (bus.cache_inst_enable && !w_wr) r_ovf <= 1'b1;
      end
   end

   always_comb begin
      bus.dec_pc   = '0;
      bus.dec_inst = '0;
      if (w_byp) begin
         bus.dec_pc   = bus.cache_pc;
         bus.dec_inst = bus.cache_inst;
      end else if (!w_empty) begin
         bus.dec_pc   = w_rdata[INST_W +: ADDR_W];
         bus.dec_inst = w_rdata[0 +: INST_W];
      end
   end

   assign bus.dec_stall    = w_empty && !w_byp;
   assign bus.pc_stall     = (CW'(DEPTH) - r_count) <= CW'(ALMOST_FULL_SLACK);
   assign bus.occupancy    = r_count;
   assign bus.overflow_err = r_ovf;
endmodule
